// File: rtl/stream_upsize_buf.sv
// Narrow-to-wide stream packer: gathers up to T_DATA_RATIO beats into one wide word
// with per-lane keep and queues committed words in an OUT_DEPTH-entry output FIFO.
module stream_upsize_buf #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DATA_RATIO = 4,
  parameter int OUT_DEPTH    = 4,
  parameter int TIMEOUT      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [T_DATA_WIDTH-1:0]       s_data_i,
  input  logic                          s_last_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic                          flush_i,
  output logic [T_DATA_WIDTH-1:0]       m_data_o [0:T_DATA_RATIO-1],
  output logic [T_DATA_RATIO-1:0]       m_keep_o,
  output logic                          m_last_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(OUT_DEPTH):0]    occupancy_o
);

  localparam int IDX_W  = $clog2(T_DATA_RATIO);
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 2);
  localparam int TO_THR = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit TO_EN  = (TIMEOUT != 0);

  typedef logic [T_DATA_WIDTH-1:0] lane_t;

  lane_t                   acc_lane_r [0:T_DATA_RATIO-1];
  logic [T_DATA_RATIO-1:0] acc_keep_r;
  logic [IDX_W-1:0]        idx_r;
  logic [IDLE_W-1:0]       idle_r;
  logic                    flush_pend_r;

  lane_t                   mem_data_r [0:OUT_DEPTH-1][0:T_DATA_RATIO-1];
  logic [T_DATA_RATIO-1:0] mem_keep_r [0:OUT_DEPTH-1];
  logic                    mem_last_r [0:OUT_DEPTH-1];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;

  lane_t                   lane_m_s [0:T_DATA_RATIO-1];
  logic [T_DATA_RATIO-1:0] keep_m_s;
  logic                    accept_s;
  logic                    full_hit_s;
  logic                    last_hit_s;
  logic                    flush_req_s;
  logic                    to_hit_s;
  logic                    fifo_full_s;
  logic                    commit_s;
  logic                    pop_s;

  // Merge the incoming beat into the accumulator and decide whether a word commits.
  always_comb begin
    fifo_full_s = (count_r == CNT_W'(OUT_DEPTH));
    s_ready_o   = ~fifo_full_s & ~rst;
    accept_s    = s_valid_i & s_ready_o;
    keep_m_s    = acc_keep_r;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      if (accept_s && (idx_r == IDX_W'(i))) begin
        lane_m_s[i] = s_data_i;
        keep_m_s[i] = 1'b1;
      end else begin
        lane_m_s[i] = acc_lane_r[i];
      end
    end
    full_hit_s  = accept_s & (idx_r == IDX_W'(T_DATA_RATIO - 1));
    last_hit_s  = accept_s & s_last_i;
    flush_req_s = (flush_i | flush_pend_r) & ((acc_keep_r != '0) | accept_s);
    // Timeout fires on the edge where the idle count would reach TIMEOUT.
    to_hit_s    = TO_EN & (acc_keep_r != '0) & ~accept_s & (idle_r >= IDLE_W'(TO_THR));
    commit_s    = (full_hit_s | last_hit_s | flush_req_s | to_hit_s) & ~fifo_full_s;
    m_valid_o   = (count_r != '0);
    pop_s       = m_valid_o & m_ready_i;
  end

  // Accumulator lanes, lane index, idle counter and deferred-flush flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < T_DATA_RATIO; i++) acc_lane_r[i] <= '0;
      acc_keep_r   <= '0;
      idx_r        <= '0;
      idle_r       <= '0;
      flush_pend_r <= 1'b0;
    end else if (commit_s) begin
      for (int i = 0; i < T_DATA_RATIO; i++) acc_lane_r[i] <= '0;
      acc_keep_r   <= '0;
      idx_r        <= '0;
      idle_r       <= '0;
      flush_pend_r <= 1'b0;
    end else begin
      if (accept_s) begin
        for (int i = 0; i < T_DATA_RATIO; i++) acc_lane_r[i] <= lane_m_s[i];
        acc_keep_r <= keep_m_s;
        idx_r      <= idx_r + IDX_W'(1);
      end
      flush_pend_r <= flush_req_s;
      if (accept_s || (acc_keep_r == '0)) begin
        idle_r <= '0;
      end else if (idle_r < IDLE_W'(TIMEOUT)) begin
        idle_r <= idle_r + IDLE_W'(1);
      end
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (commit_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({commit_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; entries are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int i = 0; i < T_DATA_RATIO; i++) mem_data_r[wr_ptr_r][i] <= lane_m_s[i];
      mem_keep_r[wr_ptr_r] <= keep_m_s;
      mem_last_r[wr_ptr_r] <= last_hit_s;
    end
  end

  // Head of FIFO drives the output; reads zero when nothing is queued.
  always_comb begin
    occupancy_o = count_r;
    if (m_valid_o) begin
      for (int i = 0; i < T_DATA_RATIO; i++) m_data_o[i] = mem_data_r[rd_ptr_r][i];
      m_keep_o = mem_keep_r[rd_ptr_r];
      m_last_o = mem_last_r[rd_ptr_r];
    end else begin
      for (int i = 0; i < T_DATA_RATIO; i++) m_data_o[i] = '0;
      m_keep_o = '0;
      m_last_o = 1'b0;
    end
  end

endmodule
